alu_arbiter: RTL and testbench

//  Shares the single combinational ALU (ALU_J) between two requesters (0: fetch/addr unit, 1: execute unit).

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters,
// with registered ALU operands and a single id-tagged, registered response channel.
module alu_arbiter #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [NumOpCodeBits-1:0] req0_opcode,
  input  logic [DataWidth-1:0]     req0_op1,
  input  logic [DataWidth-1:0]     req0_op2,
  input  logic [ParamBits-1:0]     req0_param,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [NumOpCodeBits-1:0] req1_opcode,
  input  logic [DataWidth-1:0]     req1_op1,
  input  logic [DataWidth-1:0]     req1_op2,
  input  logic [ParamBits-1:0]     req1_param,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DataWidth-1:0]     rsp_result,
  output logic [NumStatusBits-1:0] rsp_status,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   id_p0;
  logic   grant0, grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Grant stage: operands latched toward the ALU; EXEC stage: ALU output captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode   <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_param    <= '0;
      id_p0        <= 1'b0;
      last_grant   <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_status   <= '0;
    end else begin
      if (grant0 || grant1) begin
        alu_opcode   <= grant1 ? req1_opcode : req0_opcode;
        alu_operand1 <= grant1 ? req1_op1    : req0_op1;
        alu_operand2 <= grant1 ? req1_op2    : req0_op2;
        alu_param    <= grant1 ? req1_param  : req0_param;
        id_p0        <= grant1;
        last_grant   <= grant1;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_status <= alu_status;
        rsp_id     <= id_p0;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model,
// with a small stand-in ALU driven from the DUT's registered operands.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0] req0_opcode, req1_opcode;
  logic [7:0] req0_op1, req0_op2, req0_param, req1_op1, req1_op2, req1_param;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [1:0] rsp_status;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand1, alu_operand2, alu_param, alu_result;
  logic [1:0] alu_status;

  int total = 0;
  int bad = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_param(req0_param),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_param(req1_param),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_param(alu_param), .alu_result(alu_result), .alu_status(alu_status)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: status = {carry, zero} for ADD/AND, fixed pattern otherwise.
  function automatic logic [9:0] alu_fn(input logic [4:0] op, input logic [7:0] a, b, p);
    logic [8:0] s;
    case (op)
      5'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return {s[8], s[7:0] == 8'd0, s[7:0]};
      end
      5'd3:    return {1'b0, (a & b) == 8'd0, a & b};
      default: return {2'b11, a ^ b ^ p};
    endcase
  endfunction

  assign {alu_status, alu_result} = alu_fn(alu_opcode, alu_operand1, alu_operand2, alu_param);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding op, answered two edges after acceptance.
  logic       m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0;
  int         m_age = 0;
  logic [7:0] m_res = '0, m_a = '0, m_b = '0, m_p = '0;
  logic [1:0] m_st = '0;
  logic [4:0] m_op = '0;
  int         grants[$];

  always @(negedge clk) begin
    logic e0, e1, erv;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = 1'b1; m_age = 0;
      m_op = '0; m_a = '0; m_b = '0; m_p = '0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      chk("rst_rsp_result", rsp_result, 0);
    end else begin
      e0  = !m_busy && req0_valid && (!req1_valid || m_last);
      e1  = !m_busy && req1_valid && (!req0_valid || !m_last);
      erv = m_busy && m_age >= 2;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_status", rsp_status, m_st);
      end
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_operand1", alu_operand1, m_a);
      chk("alu_operand2", alu_operand2, m_b);
      chk("alu_param", alu_param, m_p);
      if (!m_busy) begin
        if (e0 || e1) begin
          m_busy = 1'b1; m_age = 1; m_id = e1; m_last = e1;
          m_op = e1 ? req1_opcode : req0_opcode;
          m_a  = e1 ? req1_op1 : req0_op1;
          m_b  = e1 ? req1_op2 : req0_op2;
          m_p  = e1 ? req1_param : req0_param;
          {m_st, m_res} = alu_fn(m_op, m_a, m_b, m_p);
          grants.push_back(int'(e1));
        end
      end else if (m_age >= 2) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) return;
    end
    chk("rsp_timeout", 0, 1);
  endtask

  task automatic set0(input logic v, input logic [4:0] op, input logic [7:0] a, b, p);
    req0_valid = v; req0_opcode = op; req0_op1 = a; req0_op2 = b; req0_param = p;
  endtask

  task automatic set1(input logic v, input logic [4:0] op, input logic [7:0] a, b, p);
    req1_valid = v; req1_opcode = op; req1_op1 = a; req1_op2 = b; req1_param = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] held;
    rst_n = 1'b0; rsp_ready = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    repeat (3) step();

    // Single op from requester 0
    rst_n = 1'b1;
    set0(1, 5'd1, 8'd1, 8'd3, 8'd0);
    @(negedge clk);
    chk("t2_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    chk("t2_latency", n, 2);
    chk("t2_id", rsp_id, 0);
    chk("t2_result", rsp_result, 4);
    step();

    // Contention from reset: grants alternate starting with requester 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grants.delete();
    set0(1, 5'd1, 8'd4, 8'd6, 8'd0);
    set1(1, 5'd3, 8'hCC, 8'hAA, 8'd0);
    for (int i = 0; i < 6; i++) begin
      wait_rsp(n);
      chk("t3_id", rsp_id, i % 2);
      chk("t3_result", rsp_result, (i % 2) ? 8'h88 : 8'd10);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_grant_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);

    // Backpressure with a competing request parked
    rsp_ready = 1'b0;
    set0(1, 5'd10, 8'h5A, 8'h0F, 8'h33);
    step();
    req0_valid = 1'b0;
    set1(1, 5'd3, 8'hF0, 8'h3C, 8'd0);
    wait_rsp(n);
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stable", rsp_result, held);
      chk("t4_ready1", req1_ready, 0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle_next", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("t4_result", rsp_result, 8'h30);
    step();

    // Overflowing ADD passes straight through; operand registers then hold
    set1(1, 5'd1, 8'd255, 8'd2, 8'd0);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("t5_result", rsp_result, 1);
    chk("t5_status", rsp_status, 2'b10);
    chk("t5_id", rsp_id, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold_op", alu_opcode, 1);
      chk("t5_hold_a", alu_operand1, 255);
      chk("t5_hold_b", alu_operand2, 2);
    end

    // Requester 1 withdraws while requester 0 is being served
    step();
    set0(1, 5'd3, 8'h0F, 8'hFF, 8'd0);
    step();
    req0_valid = 1'b0;
    set1(1, 5'd1, 8'd9, 8'd9, 8'd0);
    step();
    req1_valid = 1'b0;
    wait_rsp(n);
    chk("t6_id", rsp_id, 0);
    chk("t6_result", rsp_result, 8'h0F);
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", rsp_valid, 0);
    end

    // Reset in the middle of a held response
    rsp_ready = 1'b0;
    set0(1, 5'd1, 8'd7, 8'd8, 8'd0);
    step();
    req0_valid = 1'b0;
    wait_rsp(n);
    step();
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", rsp_valid, 0);
    chk("t1_async_opcode", alu_opcode, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_no_late_rsp", rsp_valid, 0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step();
      rsp_ready = ($urandom_range(0, 3) != 0);
      set0($urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1) * 2 + 1),
           8'($urandom), 8'($urandom), 8'($urandom));
      set1($urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1) * 2 + 1),
           8'($urandom), 8'($urandom), 8'($urandom));
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
